// File: rtl/vqueue_multimode.sv
// Register-based en/rdy FIFO with a build-time mode (normal, pipe, bypass), any depth,
// an almost-full flag and a sticky protocol-error flag.
module vqueue_multimode #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 2,
    parameter int MODE      = 0,
    parameter int AF_THRESH = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_en,
    output logic              enq_rdy,
    input  logic [DATA_W-1:0] enq_msg,
    input  logic              deq_en,
    output logic              deq_rdy,
    output logic [DATA_W-1:0] deq_msg,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              err,
    input  logic              err_clr
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C     = CNT_W'(AF_THRESH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("vqueue_multimode: MODE must be 0, 1 or 2");
    end
    if (DEPTH < 1 || DATA_W < 1 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_size
        $error("vqueue_multimode: illegal DEPTH, DATA_W or AF_THRESH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] enq_ptr;
    logic [ADDR_W-1:0] deq_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic empty;
    logic full;
    logic enq_fire;
    logic deq_fire;
    logic pass_thru;
    logic wr_en;
    logic rd_en;
    logic violation;

    // Pointers wrap by explicit compare so non-power-of-two depths never address past the last entry.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == DEPTH_C);
        enq_rdy = 1'b0;
        deq_rdy = 1'b0;
        if (!reset) begin
            if (MODE == 1) enq_rdy = !full || deq_en;
            else           enq_rdy = !full;
            if (MODE == 2) deq_rdy = !empty || enq_en;
            else           deq_rdy = !empty;
        end
        enq_fire  = enq_en && enq_rdy;
        deq_fire  = deq_en && deq_rdy;
        // An empty bypass queue hands the entry straight across without touching storage.
        pass_thru = (MODE == 2) && empty && enq_fire && deq_fire;
        wr_en     = enq_fire && !pass_thru;
        rd_en     = deq_fire && !pass_thru;
        violation = !reset && ((enq_en && !enq_rdy) || (deq_en && !deq_rdy));
        deq_msg   = (MODE == 2 && empty) ? enq_msg : mem[deq_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[enq_ptr] <= enq_msg;
                enq_ptr      <= ptr_inc(enq_ptr);
            end
            if (rd_en) deq_ptr <= ptr_inc(deq_ptr);
            if (wr_en && !rd_en)      cnt_q <= cnt_q + CNT_W'(1);
            else if (rd_en && !wr_en) cnt_q <= cnt_q - CNT_W'(1);
            // A fresh violation wins over a same-cycle clear.
            if (violation)    err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign count       = cnt_q;
    assign almost_full = (cnt_q >= AF_C);
    assign err         = err_q;

endmodule
